// File: rtl/lsu_mem_stage_if.sv
// Data-memory bus between the LSU memory stage and memory.
// Request channel (valid/ready) plus response channel (valid/ready).
interface lsu_mem_stage_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        mem_resp_ready;

    modport master (
        output mem_req_valid,
        input  mem_req_ready,
        output mem_addr,
        output mem_wen,
        output mem_wdata,
        output mem_wstrb,
        input  mem_resp_valid,
        input  mem_rdata,
        output mem_resp_ready
    );

    modport slave (
        input  mem_req_valid,
        output mem_req_ready,
        input  mem_addr,
        input  mem_wen,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_resp_valid,
        output mem_rdata,
        input  mem_resp_ready
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// LSU memory stage: one access in flight, IDLE/REQ/RESP/SEND sequencing.
// Optional LSU_MISALIGN_CHECK_EN flags misaligned word/half accesses.
module lsu_mem_stage (
    input  logic            clk,
    input  logic            rst,
    input  logic            lsu_receive_valid,
    output logic            lsu_send_ready,
    input  logic [31:0]     exu_result_i,
    input  logic [31:0]     rsb_i,
    input  logic            ren_i,
    input  logic            wen_i,
    input  logic [7:0]      wmask_i,
    input  logic [31:0]     rmask_i,
    input  logic            m_signed_i,
    input  logic            reg_en_i,
    input  logic [4:0]      rd_i,
    input  logic [31:0]     pc_next_i,
    lsu_mem_stage_if.master mem,
    output logic            lsu_send_valid,
    input  logic            wbu_receive_ready,
    output logic [31:0]     result_o,
    output logic [4:0]      rd_o,
    output logic            reg_en_o,
    output logic [31:0]     pc_next_o
`ifdef LSU_MISALIGN_CHECK_EN
    ,
    output logic            misalign_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        SEND
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0] addr_q;
    logic [31:0] rsb_q;
    logic        wen_q;
    logic [3:0]  wmask_q;
    logic [31:0] rmask_q;
    logic        signed_q;

    logic        xfer;
    logic        mis_in;
    logic        mem_acc;
    logic        resp_fire;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic        sext_byte;
    logic        sext_half;

    // Upper strobe bits are not part of a 32-bit word access.
    logic        unused_wmask;
    assign unused_wmask = ^wmask_i[7:4];

`ifdef LSU_MISALIGN_CHECK_EN
    // Classify the incoming access; stores take priority over loads.
    always_comb begin
        mis_in = 1'b0;
        if (wen_i) begin
            if (wmask_i[3:0] == 4'hF)
                mis_in = exu_result_i[1:0] != 2'b00;
            else if (wmask_i[3:0] == 4'h3)
                mis_in = exu_result_i[0];
        end else if (ren_i) begin
            if (rmask_i == 32'hFFFF_FFFF)
                mis_in = exu_result_i[1:0] != 2'b00;
            else if (rmask_i == 32'h0000_FFFF)
                mis_in = exu_result_i[0];
        end
    end
`else
    assign mis_in = 1'b0;
`endif

    assign mem_acc   = (ren_i | wen_i) & ~mis_in;
    assign xfer      = lsu_receive_valid & lsu_send_ready;
    assign resp_fire = (state == RESP) & mem.mem_resp_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state and state-decoded handshake outputs.
    always_comb begin
        state_next         = state;
        lsu_send_ready     = 1'b0;
        lsu_send_valid     = 1'b0;
        mem.mem_req_valid  = 1'b0;
        mem.mem_resp_ready = 1'b0;
        unique case (state)
            IDLE: begin
                lsu_send_ready = 1'b1;
                if (lsu_receive_valid)
                    state_next = mem_acc ? REQ : SEND;
            end
            REQ: begin
                mem.mem_req_valid = 1'b1;
                if (mem.mem_req_ready)
                    state_next = RESP;
            end
            RESP: begin
                mem.mem_resp_ready = 1'b1;
                if (mem.mem_resp_valid)
                    state_next = SEND;
            end
            SEND: begin
                lsu_send_valid = 1'b1;
                if (wbu_receive_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields come only from the captured instruction.
    assign mem.mem_addr  = {addr_q[31:2], 2'b00};
    assign mem.mem_wen   = wen_q;
    assign mem.mem_wstrb = wmask_q << addr_q[1:0];
    assign mem.mem_wdata = rsb_q << {addr_q[1:0], 3'b000};

    assign sext_byte = signed_q & (rmask_q == 32'h0000_00FF);
    assign sext_half = signed_q & (rmask_q == 32'h0000_FFFF);

    // Align the returned word, mask it and sign-extend sub-word loads.
    always_comb begin
        shifted = mem.mem_rdata >> {addr_q[1:0], 3'b000};
        unique case (1'b1)
            sext_byte: load_val = {{24{shifted[7]}}, shifted[7:0]};
            sext_half: load_val = {{16{shifted[15]}}, shifted[15:0]};
            default:   load_val = shifted & rmask_q;
        endcase
    end

    // Capture the instruction on transfer; fill the result on response.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            rsb_q      <= '0;
            wen_q      <= 1'b0;
            wmask_q    <= '0;
            rmask_q    <= '0;
            signed_q   <= 1'b0;
            result_o   <= '0;
            rd_o       <= '0;
            reg_en_o   <= 1'b0;
            pc_next_o  <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            misalign_o <= 1'b0;
`endif
        end else if (xfer) begin
            addr_q     <= exu_result_i;
            rsb_q      <= rsb_i;
            wen_q      <= wen_i;
            wmask_q    <= wmask_i[3:0];
            rmask_q    <= rmask_i;
            signed_q   <= m_signed_i;
            result_o   <= mis_in ? 32'h0 : exu_result_i;
            rd_o       <= rd_i;
            reg_en_o   <= reg_en_i & ~mis_in;
            pc_next_o  <= pc_next_i;
`ifdef LSU_MISALIGN_CHECK_EN
            misalign_o <= mis_in;
`endif
        end else if (resp_fire) begin
            result_o <= wen_q ? addr_q : load_val;
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed + randomized bench for lsu_mem_stage.
// Reference model computes expectations from the access rules directly.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_receive_valid;
    logic        lsu_send_ready;
    logic [31:0] exu_result_i;
    logic [31:0] rsb_i;
    logic        ren_i;
    logic        wen_i;
    logic [7:0]  wmask_i;
    logic [31:0] rmask_i;
    logic        m_signed_i;
    logic        reg_en_i;
    logic [4:0]  rd_i;
    logic [31:0] pc_next_i;
    logic        lsu_send_valid;
    logic        wbu_receive_ready;
    logic [31:0] result_o;
    logic [4:0]  rd_o;
    logic        reg_en_o;
    logic [31:0] pc_next_o;
`ifdef LSU_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif

    int checks = 0;
    int errors = 0;

    lsu_mem_stage_if bus ();

    lsu_mem_stage dut (
        .clk               (clk),
        .rst               (rst),
        .lsu_receive_valid (lsu_receive_valid),
        .lsu_send_ready    (lsu_send_ready),
        .exu_result_i      (exu_result_i),
        .rsb_i             (rsb_i),
        .ren_i             (ren_i),
        .wen_i             (wen_i),
        .wmask_i           (wmask_i),
        .rmask_i           (rmask_i),
        .m_signed_i        (m_signed_i),
        .reg_en_i          (reg_en_i),
        .rd_i              (rd_i),
        .pc_next_i         (pc_next_i),
        .mem               (bus),
        .lsu_send_valid    (lsu_send_valid),
        .wbu_receive_ready (wbu_receive_ready),
        .result_o          (result_o),
        .rd_o              (rd_o),
        .reg_en_o          (reg_en_o),
        .pc_next_o         (pc_next_o)
`ifdef LSU_MISALIGN_CHECK_EN
        ,
        .misalign_o        (misalign_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_mis(input logic [31:0] a, input logic r,
                                       input logic w, input logic [7:0] wm,
                                       input logic [31:0] rm);
`ifdef LSU_MISALIGN_CHECK_EN
        int off;
        off = int'(a % 4);
        if (w) begin
            if (wm[3:0] == 4'hF) return off != 0;
            if (wm[3:0] == 4'h3) return (off % 2) != 0;
            return 1'b0;
        end
        if (r) begin
            if (rm == 32'hFFFF_FFFF) return off != 0;
            if (rm == 32'h0000_FFFF) return (off % 2) != 0;
        end
        return 1'b0;
`else
        return 1'b0 & (^{a, r, w, wm, rm});
`endif
    endfunction

    function automatic logic [31:0] model_result(
        input logic [31:0] a, input logic r, input logic w,
        input logic [31:0] rm, input logic s, input logic [31:0] rdata);
        logic [31:0] sh;
        int          v;
        if (!r || w) return a;
        sh = rdata / (32'd1 << (8 * int'(a % 4)));
        if (s && rm == 32'h0000_00FF) begin
            v = $signed(sh[7:0]);
            return v;
        end
        if (s && rm == 32'h0000_FFFF) begin
            v = $signed(sh[15:0]);
            return v;
        end
        return sh & rm;
    endfunction

    task automatic scramble();
        exu_result_i = $urandom;
        rsb_i        = $urandom;
        ren_i        = 1'($urandom);
        wen_i        = 1'($urandom);
        wmask_i      = 8'($urandom);
        rmask_i      = $urandom;
        m_signed_i   = 1'($urandom);
        reg_en_i     = 1'($urandom);
        rd_i         = 5'($urandom);
        pc_next_i    = $urandom;
    endtask

    task automatic run_txn(
        input logic [31:0] a, input logic [31:0] d,
        input logic r, input logic w, input logic [7:0] wm,
        input logic [31:0] rm, input logic s, input logic [31:0] rdata,
        input int qd, input int rdl, input int wd,
        output logic [31:0] got);
        logic [31:0] e_res, e_addr, e_wdata, pcv;
        logic [3:0]  e_strb;
        logic [4:0]  rdv;
        logic        rev, mis, acc;
        int          off;
        rdv    = 5'($urandom);
        pcv    = $urandom;
        rev    = 1'($urandom);
        off    = int'(a % 4);
        mis    = model_mis(a, r, w, wm, rm);
        acc    = (r || w) && !mis;
        e_addr = a - 32'(off);
        e_strb = 4'(32'(wm[3:0]) * (32'd1 << off));
        e_wdata = 32'(d * (32'd1 << (8 * off)));
        e_res  = mis ? 32'h0 : model_result(a, r, w, rm, s, rdata);

        exu_result_i = a;
        rsb_i = d;
        ren_i = r;
        wen_i = w;
        wmask_i = wm;
        rmask_i = rm;
        m_signed_i = s;
        reg_en_i = rev;
        rd_i = rdv;
        pc_next_i = pcv;
        lsu_receive_valid = 1'b1;
        chk("idle_ready", 32'(lsu_send_ready), 32'd1);
        @(negedge clk);
        lsu_receive_valid = 1'b0;
        scramble();

        if (acc) begin
            for (int i = 0; i <= qd; i++) begin
                chk("req_valid", 32'(bus.mem_req_valid), 32'd1);
                chk("req_addr", bus.mem_addr, e_addr);
                chk("req_wen", 32'(bus.mem_wen), 32'(w));
                chk("req_wdata", bus.mem_wdata, e_wdata);
                chk("req_wstrb", 32'(bus.mem_wstrb), 32'(e_strb));
                chk("req_busy", 32'(lsu_send_ready), 32'd0);
                chk("req_rrdy", 32'(bus.mem_resp_ready), 32'd0);
                bus.mem_req_ready  = (i == qd);
                bus.mem_resp_valid = (i != qd);
                bus.mem_rdata      = $urandom;
                @(negedge clk);
            end
            bus.mem_resp_valid = 1'b0;
            for (int i = 0; i <= rdl; i++) begin
                chk("resp_rdy", 32'(bus.mem_resp_ready), 32'd1);
                chk("resp_noreq", 32'(bus.mem_req_valid), 32'd0);
                chk("resp_nosend", 32'(lsu_send_valid), 32'd0);
                bus.mem_req_ready  = 1'($urandom);
                bus.mem_resp_valid = (i == rdl);
                bus.mem_rdata      = (i == rdl) ? rdata : $urandom;
                @(negedge clk);
            end
            bus.mem_resp_valid = 1'b0;
            bus.mem_req_ready  = 1'b0;
            bus.mem_rdata      = $urandom;
        end

        got = 32'h0;
        for (int i = 0; i <= wd; i++) begin
            chk("send_valid", 32'(lsu_send_valid), 32'd1);
            chk("send_busy", 32'(lsu_send_ready), 32'd0);
            chk("send_noreq", 32'(bus.mem_req_valid), 32'd0);
            chk("result", result_o, e_res);
            chk("rd", 32'(rd_o), 32'(rdv));
            chk("reg_en", 32'(reg_en_o), 32'(rev && !mis));
            chk("pc_next", pc_next_o, pcv);
`ifdef LSU_MISALIGN_CHECK_EN
            chk("misalign", 32'(misalign_o), 32'(mis));
`endif
            got = result_o;
            wbu_receive_ready = (i == wd);
            @(negedge clk);
        end
        wbu_receive_ready = 1'b0;
        chk("back_idle", 32'(lsu_send_ready), 32'd1);
        chk("drop_valid", 32'(lsu_send_valid), 32'd0);
    endtask

    logic [31:0] got;
    logic [31:0] ra;
    logic [31:0] rm_r;
    logic [7:0]  wm_r;
    logic        rr, ww;

    initial begin
        rst = 1'b1;
        lsu_receive_valid = 1'b0;
        wbu_receive_ready = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata = 32'h0;
        scramble();
        repeat (2) @(negedge clk);

        chk("rst_send_valid", 32'(lsu_send_valid), 32'd0);
        chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_resp_rdy", 32'(bus.mem_resp_ready), 32'd0);
        chk("rst_wen", 32'(bus.mem_wen), 32'd0);
        chk("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_rd", 32'(rd_o), 32'd0);
        chk("rst_reg_en", 32'(reg_en_o), 32'd0);
        chk("rst_pc", pc_next_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(lsu_send_ready), 32'd1);

        run_txn(32'h1234, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0,
                32'h0, 0, 0, 0, got);
        chk("nonmem_result", got, 32'h1234);

        run_txn(32'h8000_0003, 32'h0, 1'b1, 1'b0, 8'h0, 32'hFF, 1'b1,
                32'h80AA_BBCC, 0, 1, 0, got);
        chk("sbyte_result", got, 32'hFFFF_FF80);

        run_txn(32'h1002, 32'h0000_BEEF, 1'b0, 1'b1, 8'h03, 32'h0, 1'b0,
                32'h0, 0, 0, 0, got);
        chk("sh_result", got, 32'h1002);

        run_txn(32'h2000_0010, 32'hCAFE_F00D, 1'b1, 1'b0, 8'h0,
                32'hFFFF_FFFF, 1'b0, 32'h1357_9BDF, 3, 2, 2, got);
        chk("bp_result", got, 32'h1357_9BDF);

        run_txn(32'h3000, 32'hA5A5_5A5A, 1'b1, 1'b1, 8'h0F,
                32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEEF, 1, 0, 1, got);
        chk("ldst_result", got, 32'h3000);

`ifdef LSU_MISALIGN_CHECK_EN
        run_txn(32'h1001, 32'h0, 1'b1, 1'b0, 8'h0, 32'hFFFF_FFFF, 1'b0,
                32'h0, 0, 0, 0, got);
        chk("mis_result", got, 32'h0);
`endif

        // Reset while waiting for the response.
        exu_result_i = 32'h2000;
        ren_i = 1'b1;
        wen_i = 1'b0;
        lsu_receive_valid = 1'b1;
        @(negedge clk);
        lsu_receive_valid = 1'b0;
        chk("rr_req", 32'(bus.mem_req_valid), 32'd1);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        chk("rr_resp", 32'(bus.mem_resp_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rr_noreq", 32'(bus.mem_req_valid), 32'd0);
        chk("rr_nosend", 32'(lsu_send_valid), 32'd0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata = 32'h7777_7777;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        repeat (2) begin
            chk("rr_late_send", 32'(lsu_send_valid), 32'd0);
            chk("rr_late_ready", 32'(lsu_send_ready), 32'd1);
            @(negedge clk);
        end

        // Reset while holding a request.
        exu_result_i = 32'h4004;
        ren_i = 1'b0;
        wen_i = 1'b1;
        wmask_i = 8'h0F;
        lsu_receive_valid = 1'b1;
        @(negedge clk);
        lsu_receive_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rq_noreq", 32'(bus.mem_req_valid), 32'd0);
        chk("rq_ready", 32'(lsu_send_ready), 32'd1);

        // Reset during SEND.
        ren_i = 1'b0;
        wen_i = 1'b0;
        lsu_receive_valid = 1'b1;
        @(negedge clk);
        lsu_receive_valid = 1'b0;
        chk("rs_send", 32'(lsu_send_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rs_nosend", 32'(lsu_send_valid), 32'd0);
        chk("rs_result", result_o, 32'd0);

        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rr = 1'($urandom);
            ww = 1'($urandom);
            case ($urandom_range(0, 2))
                0: rm_r = 32'h0000_00FF;
                1: rm_r = 32'h0000_FFFF;
                default: rm_r = 32'hFFFF_FFFF;
            endcase
            case ($urandom_range(0, 2))
                0: wm_r = 8'h01;
                1: wm_r = 8'h03;
                default: wm_r = 8'h0F;
            endcase
            run_txn(ra, $urandom, rr, ww, wm_r, rm_r, 1'($urandom),
                    $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), got);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
